imm_ext_arbiter: RTL and testbench

- Shares one registered 6-to-8-bit immediate extension unit between two pipeline requesters: decode (req 0) and branch/offset logic (req 1).
- Each requester presents a 6-bit field plus an extension mode over a valid/ready handshake.
- A round-robin arbiter grants one request per cycle into a single-entry output register.
- The result returns on one shared response channel, tagged with the requester id.

---
 rtl/imm_ext_defs.sv | 15 +
 rtl/imm_ext_unit.sv | 28 ++
 rtl/imm_ext_arbiter.sv | 79 +++++++
 tb/tb_imm_ext_arbiter.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/imm_ext_defs.sv
// Shared encodings for the immediate extension arbiter.
// Mode codes and FSM states used by the unit and the arbiter.
package imm_ext_defs;

  localparam logic [1:0] MODE_SEXT     = 2'b00;
  localparam logic [1:0] MODE_ZEXT     = 2'b01;
  localparam logic [1:0] MODE_SEXT_SH1 = 2'b10;
  localparam logic [1:0] MODE_ILL      = 2'b11;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/imm_ext_unit.sv
// Combinational immediate extender: sign, zero, or sign+shift.
// Illegal mode yields zero and raises err.
module imm_ext_unit #(
  parameter int IN_W  = 6,
  parameter int OUT_W = 8
) (
  input  logic [IN_W-1:0]  data,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] ext,
  output logic             err
);
  import imm_ext_defs::*;

  logic s;
  assign s = data[IN_W-1];

  always_comb begin
    ext = '0;
    err = 1'b0;
    unique case (mode)
      MODE_SEXT:     ext = {{(OUT_W-IN_W){s}}, data};
      MODE_ZEXT:     ext = {{(OUT_W-IN_W){1'b0}}, data};
      MODE_SEXT_SH1: ext = {{(OUT_W-IN_W-1){s}}, data, 1'b0};
      default:       err = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_ext_arbiter.sv
// Round-robin arbiter sharing one registered immediate extender
// between two requesters, with an id-tagged response channel.
module imm_ext_arbiter #(
  parameter int IN_W  = 6,
  parameter int OUT_W = 8,
  parameter int N_REQ = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*IN_W-1:0] req_data,
  input  logic [N_REQ*2-1:0]    req_mode,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [OUT_W-1:0]      rsp_data,
  output logic                  rsp_id,
  output logic                  rsp_err
);
  import imm_ext_defs::*;

  state_e           state, state_nxt;
  logic             last_grant;
  logic             can_accept;
  logic             grant;
  logic             g;
  logic [IN_W-1:0]  sel_data;
  logic [1:0]       sel_mode;
  logic [OUT_W-1:0] ext;
  logic             ext_err;

  always_comb begin
    can_accept = (state == ST_EMPTY) | rsp_ready;
    // Only contention consults last_grant; a lone requester always wins.
    g          = (&req_valid) ? ~last_grant : req_valid[1];
    grant      = can_accept & (|req_valid) & ~rst;
    req_ready  = '0;
    if (grant) req_ready[g] = 1'b1;
    sel_data   = g ? req_data[2*IN_W-1:IN_W] : req_data[IN_W-1:0];
    sel_mode   = g ? req_mode[3:2] : req_mode[1:0];
    state_nxt  = state;
    unique case (state)
      ST_EMPTY: if (grant) state_nxt = ST_FULL;
      ST_FULL:  if (rsp_ready) state_nxt = grant ? ST_FULL : ST_EMPTY;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  imm_ext_unit #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_ext (
    .data (sel_data),
    .mode (sel_mode),
    .ext  (ext),
    .err  (ext_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_EMPTY;
      last_grant <= 1'b1;
      rsp_data   <= '0;
      rsp_id     <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        last_grant <= g;
        rsp_data   <= ext;
        rsp_id     <= g;
        rsp_err    <= ext_err;
      end
    end
  end

  assign rsp_valid = (state == ST_FULL);

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Directed, table-driven bench for imm_ext_arbiter.
// Cycle vectors plus hand-written async reset sequence.
module tb_imm_ext_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [11:0] req_data;
  logic [3:0]  req_mode;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic        rsp_id;
  logic        rsp_err;

  int n_tests = 0;
  int n_fail  = 0;

  imm_ext_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_mode  (req_mode),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] v;
    logic [5:0] d0;
    logic [1:0] m0;
    logic [5:0] d1;
    logic [1:0] m1;
    logic       rr;
    logic [1:0] e_rdy;
    logic       e_val;
    logic [7:0] e_data;
    logic       e_id;
    logic       e_err;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [5:0] d0,
                       input logic [1:0] m0, input logic [5:0] d1,
                       input logic [1:0] m1, input logic rr);
    req_valid = v;
    req_data  = {d1, d0};
    req_mode  = {m1, m0};
    rsp_ready = rr;
  endtask

  initial begin
    rst = 1'b1;
    drive(2'b00, 6'h0, 2'b00, 6'h0, 2'b00, 1'b0);

    // single requests, sign/zero/shift
    tbl.push_back('{2'b01, 6'h25, 2'b00, 6'h00, 2'b00, 1'b1, 2'b01, 1'b1, 8'hE5, 1'b0, 1'b0});
    tbl.push_back('{2'b01, 6'h25, 2'b01, 6'h00, 2'b00, 1'b1, 2'b01, 1'b1, 8'h25, 1'b0, 1'b0});
    tbl.push_back('{2'b01, 6'h25, 2'b10, 6'h00, 2'b00, 1'b1, 2'b01, 1'b1, 8'hCA, 1'b0, 1'b0});
    // illegal mode from req1
    tbl.push_back('{2'b10, 6'h00, 2'b00, 6'h15, 2'b11, 1'b1, 2'b10, 1'b1, 8'h00, 1'b1, 1'b1});
    // drain, then idle consumer while empty
    tbl.push_back('{2'b00, 6'h00, 2'b00, 6'h00, 2'b00, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0});
    tbl.push_back('{2'b00, 6'h00, 2'b00, 6'h00, 2'b00, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0});
    // contention: grants 0,1,0,1 with no bubbles
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0)
        tbl.push_back('{2'b11, 6'h01, 2'b00, 6'h3F, 2'b00, 1'b1, 2'b01, 1'b1, 8'h01, 1'b0, 1'b0});
      else
        tbl.push_back('{2'b11, 6'h01, 2'b00, 6'h3F, 2'b00, 1'b1, 2'b10, 1'b1, 8'hFF, 1'b1, 1'b0});
    end
    // backpressure: one accept, then hold with req1 waiting
    tbl.push_back('{2'b01, 6'h01, 2'b00, 6'h00, 2'b00, 1'b1, 2'b01, 1'b1, 8'h01, 1'b0, 1'b0});
    for (int i = 0; i < 3; i++)
      tbl.push_back('{2'b10, 6'h00, 2'b00, 6'h3F, 2'b10, 1'b0, 2'b00, 1'b1, 8'h01, 1'b0, 1'b0});
    tbl.push_back('{2'b10, 6'h00, 2'b00, 6'h3F, 2'b10, 1'b1, 2'b10, 1'b1, 8'hFE, 1'b1, 1'b0});
    tbl.push_back('{2'b00, 6'h00, 2'b00, 6'h00, 2'b00, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0});

    #1;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_data", 32'(rsp_data), 32'd0);
    chk("reset_rsp_id", 32'(rsp_id), 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].v, tbl[i].d0, tbl[i].m0, tbl[i].d1, tbl[i].m1, tbl[i].rr);
      #1;
      chk($sformatf("v%0d_req_ready", i), 32'(req_ready), 32'(tbl[i].e_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].e_val));
      if (tbl[i].e_val) begin
        chk($sformatf("v%0d_rsp_data", i), 32'(rsp_data), 32'(tbl[i].e_data));
        chk($sformatf("v%0d_rsp_id", i), 32'(rsp_id), 32'(tbl[i].e_id));
        chk($sformatf("v%0d_rsp_err", i), 32'(rsp_err), 32'(tbl[i].e_err));
      end
    end

    // fill the register from req1, then reset between edges
    @(negedge clk);
    drive(2'b10, 6'h00, 2'b00, 6'h3F, 2'b00, 1'b0);
    @(posedge clk);
    #1;
    chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
    chk("pre_rst_data", 32'(rsp_data), 32'hFF);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(rsp_valid), 32'd0);
    chk("async_rst_data", 32'(rsp_data), 32'd0);
    chk("async_rst_id", 32'(rsp_id), 32'd0);
    drive(2'b11, 6'h01, 2'b00, 6'h3F, 2'b00, 1'b1);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_hold_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_grant", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("post_rst_valid", 32'(rsp_valid), 32'd1);
    chk("post_rst_data", 32'(rsp_data), 32'h01);
    chk("post_rst_id", 32'(rsp_id), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
